// File: rtl/md_unit_pkg.sv
// md_defs: shared definitions for the multiply/divide unit.
//   - md_op_e       : operation codes presented on md_op
//   - *_CYCLES_DEF  : default busy durations for multiply and divide
//   - abs32         : magnitude of a 32-bit two's-complement value
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // 0x80000000 maps to itself, which reads correctly as an unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset, clears all state
//   start  in   qualifies md_op this cycle
//   md_op  in   operation code (md_defs::md_op_e)
//   A      in   operand 1 (rs; dividend)
//   B      in   operand 2 (rt; divisor)
//   busy   out  operation in flight (registered)
//   hi     out  HI register
//   lo     out  LO register
// The result is computed at accept time into pending registers and committed
// to HI/LO on the last busy edge, so busy only models the latency.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_load_s;
  logic             busy_q;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic             accept_s;
  logic             load_s;
  logic             done_s;
  md_op_e           op_s;

  logic [63:0] mul_s_s, mul_u_s;
  logic [31:0] b_nz_s;
  logic [31:0] a_mag_s, b_mag_s, q_mag_s, r_mag_s;
  logic [31:0] divs_q_s, divs_r_s, divu_q_s, divu_r_s;

  assign op_s     = md_op_e'(md_op);
  assign accept_s = start && !busy_q;
  assign done_s   = busy_q && (cnt_q == CNT_W'(1));

  // Arithmetic datapath: products and quotients from the current operands.
  always_comb begin
    mul_s_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    mul_u_s = {32'd0, A} * {32'd0, B};
    // Zero divisor is replaced by 1 so the divider never sees /0; the result
    // is discarded anyway because pend_wr stays low.
    if (B == 32'd0) begin
      b_nz_s  = 32'd1;
      b_mag_s = 32'd1;
    end else begin
      b_nz_s  = B;
      b_mag_s = abs32(B);
    end
    divu_q_s = A / b_nz_s;
    divu_r_s = A % b_nz_s;
    // Signed divide on magnitudes: quotient sign is sign(A)^sign(B),
    // remainder follows the dividend. 0x80000000 / -1 yields 0x80000000.
    a_mag_s  = abs32(A);
    q_mag_s  = a_mag_s / b_mag_s;
    r_mag_s  = a_mag_s % b_mag_s;
    if (A[31] ^ B[31]) begin
      divs_q_s = 32'd0 - q_mag_s;
    end else begin
      divs_q_s = q_mag_s;
    end
    if (A[31]) begin
      divs_r_s = 32'd0 - r_mag_s;
    end else begin
      divs_r_s = r_mag_s;
    end
  end

  // Operation decode: selects the pending result and busy duration.
  always_comb begin
    load_s     = 1'b0;
    cnt_load_s = '0;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    pend_wr_d  = pend_wr_q;
    case (op_s)
      MD_MULT: begin
        load_s     = 1'b1;
        cnt_load_s = CNT_W'(MULT_CYCLES);
        pend_hi_d  = mul_s_s[63:32];
        pend_lo_d  = mul_s_s[31:0];
        pend_wr_d  = 1'b1;
      end
      MD_MULTU: begin
        load_s     = 1'b1;
        cnt_load_s = CNT_W'(MULT_CYCLES);
        pend_hi_d  = mul_u_s[63:32];
        pend_lo_d  = mul_u_s[31:0];
        pend_wr_d  = 1'b1;
      end
      MD_DIV: begin
        load_s     = 1'b1;
        cnt_load_s = CNT_W'(DIV_CYCLES);
        pend_hi_d  = divs_r_s;
        pend_lo_d  = divs_q_s;
        pend_wr_d  = (B != 32'd0);
      end
      MD_DIVU: begin
        load_s     = 1'b1;
        cnt_load_s = CNT_W'(DIV_CYCLES);
        pend_hi_d  = divu_r_s;
        pend_lo_d  = divu_q_s;
        pend_wr_d  = (B != 32'd0);
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // HI/LO next state: commit pending result, or direct moves from A.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (done_s) begin
      if (pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end else begin
        hi_d = hi_q;
      end
    end else if (accept_s) begin
      case (op_s)
        MD_MTHI: hi_d = A;
        MD_MTLO: lo_d = A;
        default: hi_d = hi_q;
      endcase
    end else begin
      hi_d = hi_q;
    end
  end

  // Busy counter: loaded on accept, counts down, busy drops on 1->0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (accept_s && load_s) begin
      cnt_q  <= cnt_load_s;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      busy_q <= (cnt_q != CNT_W'(1));
    end
  end

  // Pending result registers, captured at accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else if (accept_s && load_s) begin
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
